// File: rtl/bsg_cgol_pkg.sv
// Shared types and helpers for the CGoL board datapath: serializer state encoding
// and the cell index convention used by the cell array and the (de)serializers.
package bsg_cgol_pkg;

    typedef enum logic {
        eIDLE = 1'b0,
        eSEND = 1'b1
    } bsg_cgol_ser_state_e;

    // Cell (r,c) of a board_len x board_len board lives at bit r*board_len+c.
    function automatic int unsigned cell_idx(input int unsigned r, input int unsigned c,
                                             input int unsigned board_len);
        return r * board_len + c;
    endfunction

    // clog2 that never returns 0, so a 1-value counter still gets one bit.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return ($clog2(n) > 0) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_cgol_piso_shift.sv
// Loadable parallel-in/serial-out register shifting right by shift_p bits per step,
// zero-filled; exposes the low shift_p bits as the current word.
module bsg_cgol_piso_shift #(
    parameter int unsigned width_p = 64,
    parameter int unsigned shift_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [width_p-1:0] data_i,
    input  logic               shift_i,
    output logic [shift_p-1:0] data_o
);

    logic [width_p-1:0] r_data;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_data <= '0;
        end else if (load_i) begin
            r_data <= data_i;
        end else if (shift_i) begin
            r_data <= r_data >> shift_p;
        end
    end

    assign data_o = r_data[shift_p-1:0];

endmodule

// File: rtl/bsg_cgol_board_serializer.sv
// Captures a finished CGoL board in parallel and streams it out as data_width_p words.
// Optional trailing XOR checksum beat when BSG_CGOL_SERIALIZER_CHECKSUM_EN is defined.
module bsg_cgol_board_serializer
    import bsg_cgol_pkg::*;
#(
    parameter int unsigned board_len_p  = 8,
    parameter int unsigned data_width_p = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [board_len_p*board_len_p-1:0]   board_i,
    input  logic                                 v_i,
    output logic                                 yumi_o,
    output logic [data_width_p-1:0]              data_o,
    output logic                                 v_o,
    input  logic                                 ready_i,
    output logic                                 last_o
);

    localparam int unsigned cells_lp     = board_len_p * board_len_p;
    localparam int unsigned words_lp     = cells_lp / data_width_p;
    localparam int unsigned cnt_width_lp = safe_clog2(words_lp + 1);
`ifdef BSG_CGOL_SERIALIZER_CHECKSUM_EN
    localparam logic [cnt_width_lp-1:0] last_idx_lp = cnt_width_lp'(words_lp);
`else
    localparam logic [cnt_width_lp-1:0] last_idx_lp = cnt_width_lp'(words_lp - 1);
`endif

    bsg_cgol_ser_state_e       r_state;
    logic [cnt_width_lp-1:0]   r_cnt;
    logic [data_width_p-1:0]   w_word;
    logic                      w_xfer;
    logic                      w_last;

    assign yumi_o = (r_state == eIDLE) & v_i;
    assign v_o    = (r_state == eSEND);
    assign w_xfer = v_o & ready_i;
    assign w_last = v_o & (r_cnt == last_idx_lp);
    assign last_o = w_last;

    bsg_cgol_piso_shift #(
        .width_p (cells_lp),
        .shift_p (data_width_p)
    ) shift_u (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (yumi_o),
        .data_i  (board_i),
        .shift_i (w_xfer),
        .data_o  (w_word)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= eIDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                eIDLE: begin
                    if (v_i) begin
                        r_state <= eSEND;
                        r_cnt   <= '0;
                    end
                end
                eSEND: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) r_state <= eIDLE;
                    end
                end
                default: r_state <= eIDLE;
            endcase
        end
    end

`ifdef BSG_CGOL_SERIALIZER_CHECKSUM_EN
    logic [data_width_p-1:0] r_csum;
    logic                    w_csum_beat;

    assign w_csum_beat = (r_cnt == cnt_width_lp'(words_lp));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_csum <= '0;
        end else if (yumi_o) begin
            r_csum <= '0;
        end else if (w_xfer && !w_csum_beat) begin
            r_csum <= r_csum ^ w_word;
        end
    end

    assign data_o = !v_o ? '0 : (w_csum_beat ? r_csum : w_word);
`else
    assign data_o = v_o ? w_word : '0;
`endif

endmodule

// File: tb/tb_bsg_cgol_board_serializer.sv
// Randomized and directed checks of bsg_cgol_board_serializer (4x4 board, 4-bit words)
// plus a single-word 2x2 instance, against an arithmetic model of the output stream.
module tb_bsg_cgol_board_serializer;

`ifdef BSG_CGOL_SERIALIZER_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif
    localparam int WORDS = 4;
    localparam int NB    = WORDS + CSUM;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [15:0] board_i;
    logic        v_i, ready_i;
    logic        yumi_o, v_o, last_o;
    logic [3:0]  data_o;

    logic [3:0]  board1_i;
    logic        v1_i, ready1_i;
    logic        yumi1_o, v1_o, last1_o;
    logic [3:0]  data1_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bsg_cgol_board_serializer #(.board_len_p(4), .data_width_p(4)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .board_i (board_i),
        .v_i     (v_i),
        .yumi_o  (yumi_o),
        .data_o  (data_o),
        .v_o     (v_o),
        .ready_i (ready_i),
        .last_o  (last_o)
    );

    bsg_cgol_board_serializer #(.board_len_p(2), .data_width_p(4)) dut1 (
        .clk_i   (clk),
        .reset_i (reset_i),
        .board_i (board1_i),
        .v_i     (v1_i),
        .yumi_o  (yumi1_o),
        .data_o  (data1_o),
        .v_o     (v1_o),
        .ready_i (ready1_i),
        .last_o  (last1_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word k of a board is board bits [4k +: 4]; the optional extra beat is their XOR.
    function automatic logic [3:0] exp_word(input logic [15:0] b, input int k);
        logic [3:0] x = 4'h0;
        if (k < WORDS) return 4'((b >> (4 * k)) & 16'hF);
        for (int i = 0; i < WORDS; i++) x ^= 4'((b >> (4 * i)) & 16'hF);
        return x;
    endfunction

    // Called #1 after a rising edge. mode 0: ready always high, 1: random, 2: low 3 cycles.
    task automatic stream(input logic [15:0] b, input int mode, input bit hold,
                          input logic [15:0] nb);
        int idx = 0;
        int cyc = 0;
        v_i = 1'b1; board_i = b; ready_i = 1'b0;
        @(negedge clk);
        chk("yumi_on_capture", yumi_o, 1);
        chk("idle_v_o", v_o, 0);
        @(posedge clk); #1;
        if (hold) board_i = nb; else v_i = 1'b0;
        while (idx < NB && cyc < 200) begin
            case (mode)
                0:       ready_i = 1'b1;
                2:       ready_i = (cyc >= 3);
                default: ready_i = ($urandom_range(0, 99) < 60);
            endcase
            @(negedge clk);
            chk("send_v_o", v_o, 1);
            chk("send_data_o", data_o, exp_word(b, idx));
            chk("send_last_o", last_o, (idx == NB - 1));
            chk("send_yumi_o", yumi_o, 0);
            @(posedge clk); #1;
            if (ready_i) idx++;
            cyc++;
        end
        chk("beat_count", idx, NB);
        ready_i = 1'b0;
        if (!hold) begin
            @(negedge clk);
            chk("after_v_o", v_o, 0);
            chk("after_last_o", last_o, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset_i = 1'b1; v_i = 1'b0; ready_i = 1'b0; board_i = '0;
        v1_i = 1'b0; ready1_i = 1'b0; board1_i = '0;
        #2;
        chk("reset_v_o", v_o, 0);
        chk("reset_yumi_o", yumi_o, 0);
        chk("reset_last_o", last_o, 0);
        chk("reset_data_o", data_o, 0);
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        @(posedge clk); #1;

        // Basic stream and back-pressure on the same board.
        stream(16'hA5C3, 0, 1'b0, 16'h0);
        stream(16'hA5C3, 2, 1'b0, 16'h0);

        // Back-to-back boards with v_i held high; second call observes the bubble.
        stream(16'h1234, 0, 1'b1, 16'hFFFF);
        stream(16'hFFFF, 0, 1'b0, 16'h0);

        // Randomized boards under random back-pressure.
        for (int n = 0; n < 12; n++) stream(16'($urandom), 1, 1'b0, 16'h0);

        // Async reset after the 2nd beat, asserted between edges.
        v_i = 1'b1; board_i = 16'hBEEF;
        @(posedge clk); #1;
        v_i = 1'b0; ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset_i = 1'b1;
        #1;
        chk("abort_v_o", v_o, 0);
        chk("abort_last_o", last_o, 0);
        chk("abort_data_o", data_o, 0);
        ready_i = 1'b0;
        @(negedge clk); #2 reset_i = 1'b0;
        @(posedge clk); #1;
        stream(16'h7E51, 0, 1'b0, 16'h0);

        // Single-word configuration.
        v1_i = 1'b1; board1_i = 4'h9; ready1_i = 1'b1;
        @(negedge clk);
        chk("one_yumi_o", yumi1_o, 1);
        @(posedge clk); #1;
        v1_i = 1'b0;
        for (int k = 0; k <= CSUM; k++) begin
            @(negedge clk);
            chk("one_v_o", v1_o, 1);
            chk("one_data_o", data1_o, 4'h9);
            chk("one_last_o", last1_o, (k == CSUM));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("one_after_v_o", v1_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bsg_cgol_board_serializer.md
Name: bsg_cgol_board_serializer

Overview:
- Downstream stage of the CGoL controller and cell array.
- Once a game finishes, the controller raises its done-valid. This block captures the full board_len_p x board_len_p cell array in parallel and acknowledges with yumi_o.
- It then streams the board out as fixed-width words over a valid/ready channel toward the chip output link.
- It frees the cell array as soon as the board is captured, so the next game can be loaded while serialization proceeds.

Parameters:
- board_len_p, 8: board edge length; the board holds board_len_p*board_len_p cells.
- data_width_p, 8: output word width. Must evenly divide board_len_p*board_len_p.
- Derived localparam words_lp = board_len_p*board_len_p/data_width_p.
- Derived localparam cnt_width_lp = `BSG_SAFE_CLOG2(words_lp+1).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  reset, asynchronous and active-high.
- board_i  in  board_len_p*board_len_p  cell array state. Cell (r,c) is at bit r*board_len_p+c.
- v_i  in  1  board valid (driven by the controller's done-valid).
- yumi_o  out  1  board consumed this cycle.
- data_o  out  data_width_p  output word.
- v_o  out  1  output word valid.
- ready_i  in  1  downstream ready.
- last_o  out  1  qualifies the final word of a board.

Behaviour:
- States: eIDLE and eSEND. Reset is async and active-high, and places the block in the following state:
  - state = eIDLE
  - shift register = 0
  - word counter = 0
  - v_o = 0, yumi_o = 0, last_o = 0, data_o = 0
- yumi_o = (state==eIDLE) & v_i. This is combinational; upstream must not depend on yumi_o to drive v_i.
- On yumi_o:
  - shift register <= board_i
  - counter <= 0
  - state <= eSEND (next cycle)
- Capture-to-first-valid latency is 1 cycle.
- In eSEND:
  - v_o = 1.
  - data_o = shift register [data_width_p-1:0], so word k carries board bits [k*data_width_p +: data_width_p].
  - v_o is never deasserted while eSEND is active; the word is held stable until accepted.
- On transfer (v_o & ready_i):
  - shift register shifts right by data_width_p, zero-filled.
  - counter increments.
- last_o = v_o & (counter == words_lp-1).
- A transfer with last_o set returns the block to eIDLE next cycle.
- There is a 1-cycle bubble between boards: yumi_o cannot assert in the same cycle as the last transfer.
- Back-pressure: if ready_i is low, data_o, last_o and the counter hold indefinitely.
- v_i while in eSEND is ignored; yumi_o stays 0 and upstream holds the board.
- words_lp == 1: the first word is also last; the board is transferred in one beat.
- Reset mid-serialization aborts the board immediately. The partial stream is discarded, and no last_o is ever issued for it.
- The counter never exceeds words_lp (or words_lp+1 with the optional feature) and cannot wrap.

Optional Feature:
- Macro: BSG_CGOL_SERIALIZER_CHECKSUM_EN.
- Enabled:
  - A data_width_p checksum register is cleared on capture and XORs in every data word on transfer.
  - After the final data word, one extra beat carries the checksum.
  - On that extra beat, data_o = checksum and last_o = 1; last_o is not set on the final data word.
  - The block emits words_lp+1 beats per board.
- Disabled:
  - The checksum register and its logic are absent.
  - The block emits exactly words_lp beats, with last_o on data word words_lp-1.

Decomposition:
- Package bsg_cgol_pkg holds:
  - the shared state typedef for this block (eIDLE/eSEND)
  - the cell index convention function/constant (r*board_len_p+c), shared with the cell array and input deserializer.
- One natural sub-module: bsg_cgol_piso_shift.
  - Loadable right-shift register with load_i, shift_i and data_o.
  - The top level holds the FSM, counter and optional checksum.

Test Plan (board_len_p=4, data_width_p=4, words_lp=4 unless noted):
- Basic stream:
  - Stimulus: board_i=16'hA5C3, v_i=1, ready_i=1 throughout.
  - Response: yumi_o pulses 1 cycle; the next 4 cycles give data_o=3,C,5,A; last_o on the 4th beat only; then v_o=0.
- Back-pressure:
  - Stimulus: same board, ready_i low for 3 cycles after the first valid.
  - Response: data_o holds 3 and v_o stays 1; the sequence resumes unchanged with the same 4 words.
- Back-to-back boards:
  - Stimulus: v_i held high with 16'h1234, then 16'hFFFF.
  - Response: words 4,3,2,1; one idle bubble; yumi_o for the second board; words F,F,F,F.
- Async reset mid-stream:
  - Stimulus: assert reset_i between clock edges after the 2nd beat.
  - Response: v_o, last_o and data_o go to 0 immediately; after release, a new board starts at word 0.
- Single-word config (board_len_p=2, data_width_p=4):
  - Stimulus: board_i=4'h9.
  - Response: one beat with data_o=9 and last_o=1.
- Checksum (with BSG_CGOL_SERIALIZER_CHECKSUM_EN):
  - Stimulus: board 16'hA5C3.
  - Response: 5 beats 3,C,5,A,0; last_o only on beat 5. The checksum value is 3^C^5^A = 0.
